uv_arb_wrr: RTL and testbench
=============================

Name: uv_arb_wrr

Overview:
Parametrised, registered, lock-capable arbiter for shared-resource access: bus masters to an interconnect port, or DMA channels to a memory port.
Selects one of WIDTH requesters using round-robin, weighted round-robin or fixed-priority mode.
Holds the grant across multi-beat transfers until the granted requester signals completion (ack & last).
Supersedes the single-cycle combinational round-robin arbiter wherever bursts, weights or fixed priority are needed.

Parameters:
WIDTH, 4, number of requesters (>=2).
CNT_W, 4, width of each per-requester weight/credit field.
IDX_W, $clog2(WIDTH), localparam; width of grant_idx.

Ports:
clk  input  1  clock.
rst_n  input  1  synchronous active-low reset, sampled on rising clk.
mode  input  2  0=round-robin, 1=weighted RR, 2=fixed priority (req[0] highest), 3=reserved (treated as 0).
weight  input  WIDTH*CNT_W  weight[i*CNT_W +: CNT_W] = consecutive transactions allowed for requester i in mode 1.
req  input  WIDTH  request vector.
ack  input  1  current beat of granted transfer accepted.
last  input  1  qualifies ack as the final beat of a transaction.
grant  output  WIDTH  registered one-hot grant; all-zero when idle.
grant_idx  output  IDX_W  binary index of the granted requester; holds its last value when idle.
grant_vld  output  1  equals |grant.

Behaviour:
- Reset values (rst_n low at a clk edge):
  - grant=0, grant_idx=0, grant_vld=0.
  - State IDLE.
  - Priority pointer = one-hot bit 0.
  - Credit counter = 0.
- Reset mid-transfer aborts the lock immediately. No further grant is issued until rst_n is high and arbitration runs from IDLE.
- FSM states: IDLE, GRANT.
- IDLE:
  - If |req, register the winner.
  - Next cycle: state=GRANT, grant=onehot(winner), grant_idx=winner.
  - Latency from req to grant is 1 cycle.
  - If req==0, stay in IDLE with grant=0.
- Winner selection:
  - Modes 0, 1, 3: first asserted req at or above the pointer position, wrapping from WIDTH-1 to 0. Use a double-width mask-and-subtract or an equivalent circular search.
  - Mode 2: lowest asserted index. The pointer is not updated.
- Credit load at selection:
  - Mode 1: credit = weight[winner]; a weight of 0 is treated as 1.
  - Other modes: credit = 1.
  - Weight and mode are sampled only at selection. Changes during GRANT take effect at the next arbitration.
- GRANT:
  - grant is held constant regardless of req changes. A requester dropping req does not release the lock.
  - ack without last: no state change.
  - ack & last with credit > 1 and req[grant_idx] still high in that cycle: stay in GRANT with the same grant; credit decrements.
  - ack & last otherwise: release, i.e. state=IDLE, grant=0 next cycle.
    - Modes 0/1/3: pointer = rotate-left(onehot(grant_idx)), so the next requester gets top priority.
    - Mode 2: pointer unchanged.
    - Credit cleared.
- Release always costs one idle bubble cycle: grant_vld is low for exactly 1 cycle before the next grant.
- ack while IDLE is ignored.
- grant is always one-hot or zero, never multi-hot.
- Credit arithmetic: CNT_W-bit unsigned, never underflows; decrement only when credit > 1.

Test Plan:
1. Reset then mode 0, req=4'b1111, ack=last=1 every cycle -> grants 0001,0000,0010,0000,0100,0000,1000,0000,0001, repeating; grant_idx 0,1,2,3.
2. Mode 1, weights {1,1,1,3} (req3=3), req=4'b1001, ack=last=1 every cycle -> req0 granted 1 cycle, bubble, req3 held 3 consecutive cycles, bubble, then req0.
3. Mode 2, req=4'b1110 held, single-beat transfers -> req1 granted every time; req2/req3 never granted while req1 is asserted.
4. Mode 0, req1 alone; ack=1,last=0 for 3 cycles, then ack=last=1; req1 deasserted after cycle 1 and req2 asserted -> grant stays 0010 until the last beat, bubble, then 0100.
5. Mode 1 with weight[0]=0, req=4'b0001 -> behaves as weight 1: grant, release, bubble, regrant. Mode changed to 2 mid-grant -> current grant completes unchanged.
6. Mid-GRANT assertion of rst_n low for 1 cycle -> next cycle grant=0, grant_idx=0, pointer at bit 0. With req=4'b1010 after reset release, mode 0 -> req1 granted first.

Source files
------------

// File: rtl/uv_arb_wrr.sv
// Registered round-robin / weighted round-robin / fixed-priority arbiter.
// A grant is locked until the owner completes a transaction (ack & last) and its credit is spent.
module uv_arb_wrr #(
  parameter  int WIDTH = 4,
  parameter  int CNT_W = 4,
  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [1:0]             mode,
  input  logic [WIDTH*CNT_W-1:0] weight,
  input  logic [WIDTH-1:0]       req,
  input  logic                   ack,
  input  logic                   last,
  output logic [WIDTH-1:0]       grant,
  output logic [IDX_W-1:0]       grant_idx,
  output logic                   grant_vld
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t             state_reg, state_next;
  logic [WIDTH-1:0]   ptr_reg, ptr_next;
  logic [CNT_W-1:0]   credit_reg, credit_next;
  logic [WIDTH-1:0]   grant_reg, grant_next;
  logic [IDX_W-1:0]   grant_idx_reg, grant_idx_next;
  logic               fixed_reg, fixed_next;

  logic [CNT_W-1:0]   weight_arr [WIDTH];
  logic [2*WIDTH-1:0] req_dbl;
  logic [2*WIDTH-1:0] rr_dbl;
  logic [WIDTH-1:0]   rr_oh;
  logic [WIDTH-1:0]   fp_oh;
  logic [WIDTH-1:0]   win_oh;
  logic [IDX_W-1:0]   win_idx;
  logic [CNT_W-1:0]   win_weight;
  logic               is_fixed;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_weight
      assign weight_arr[gi] = weight[gi*CNT_W +: CNT_W];
    end
  endgenerate

  // Circular search from the pointer: subtracting the one-hot pointer from the
  // doubled request vector clears everything below the first request at/after it.
  assign req_dbl  = {req, req};
  assign rr_dbl   = req_dbl & ~(req_dbl - {{WIDTH{1'b0}}, ptr_reg});
  assign rr_oh    = rr_dbl[WIDTH-1:0] | rr_dbl[2*WIDTH-1:WIDTH];
  assign fp_oh    = req & (~req + {{(WIDTH-1){1'b0}}, 1'b1});
  assign is_fixed = (mode == 2'd2);
  assign win_oh   = is_fixed ? fp_oh : rr_oh;

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (win_oh[i]) win_idx = IDX_W'(i);
    end
  end

  assign win_weight = weight_arr[win_idx];

  always_comb begin
    state_next     = state_reg;
    ptr_next       = ptr_reg;
    credit_next    = credit_reg;
    grant_next     = grant_reg;
    grant_idx_next = grant_idx_reg;
    fixed_next     = fixed_reg;
    case (state_reg)
      IDLE: begin
        if (|req) begin
          state_next     = GRANT;
          grant_next     = win_oh;
          grant_idx_next = win_idx;
          fixed_next     = is_fixed;
          if (mode == 2'd1 && win_weight != '0) credit_next = win_weight;
          else                                  credit_next = CNT_W'(1);
        end
      end
      GRANT: begin
        if (ack && last) begin
          if (credit_reg > CNT_W'(1) && |(req & grant_reg)) begin
            credit_next = credit_reg - CNT_W'(1);
          end else begin
            state_next  = IDLE;
            grant_next  = '0;
            credit_next = '0;
            // Owner goes to the back of the queue; fixed priority leaves the pointer alone.
            if (!fixed_reg) ptr_next = {grant_reg[WIDTH-2:0], grant_reg[WIDTH-1]};
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      ptr_reg       <= {{(WIDTH-1){1'b0}}, 1'b1};
      credit_reg    <= '0;
      grant_reg     <= '0;
      grant_idx_reg <= '0;
      fixed_reg     <= 1'b0;
    end else begin
      state_reg     <= state_next;
      ptr_reg       <= ptr_next;
      credit_reg    <= credit_next;
      grant_reg     <= grant_next;
      grant_idx_reg <= grant_idx_next;
      fixed_reg     <= fixed_next;
    end
  end

  assign grant     = grant_reg;
  assign grant_idx = grant_idx_reg;
  assign grant_vld = |grant_reg;

endmodule

// File: tb/tb_uv_arb_wrr.sv
// Bench for uv_arb_wrr: directed scenarios plus random traffic, checked every cycle
// against an integer-level model of the arbitration rules.
module tb_uv_arb_wrr;

  localparam int WIDTH = 4;
  localparam int CNT_W = 4;
  localparam int IDX_W = 2;

  logic                   clk;
  logic                   rst_n;
  logic [1:0]             mode;
  logic [WIDTH*CNT_W-1:0] weight;
  logic [WIDTH-1:0]       req;
  logic                   ack;
  logic                   last;
  logic [WIDTH-1:0]       grant;
  logic [IDX_W-1:0]       grant_idx;
  logic                   grant_vld;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: who owns the resource, how many transactions remain, who is next in line.
  int m_busy, m_owner, m_idx, m_credit, m_ptr, m_fixed;

  uv_arb_wrr #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .weight    (weight),
    .req       (req),
    .ack       (ack),
    .last      (last),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_vld (grant_vld)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_idx = 0; m_credit = 0; m_ptr = 0; m_fixed = 0;
  endtask

  task automatic model_update(input logic r, input logic [1:0] m, input logic [WIDTH*CNT_W-1:0] w,
                              input logic [WIDTH-1:0] rq, input logic a, input logic l);
    int win, wt;
    if (!r) begin
      model_reset();
    end else if (!m_busy) begin
      if (rq != 0) begin
        win = -1;
        if (m == 2) begin
          for (int i = 0; i < WIDTH; i++) if (win < 0 && rq[i]) win = i;
        end else begin
          for (int k = 0; k < WIDTH; k++) if (win < 0 && rq[(m_ptr + k) % WIDTH]) win = (m_ptr + k) % WIDTH;
        end
        wt = int'((w >> (win * CNT_W)) & ((1 << CNT_W) - 1));
        m_busy   = 1;
        m_owner  = win;
        m_idx    = win;
        m_fixed  = (m == 2);
        m_credit = (m == 1) ? ((wt == 0) ? 1 : wt) : 1;
        $display("[TB] grant to %0d mode=%0d credit=%0d", win, m, m_credit);
      end
    end else if (a && l) begin
      if (m_credit > 1 && rq[m_owner]) begin
        m_credit--;
      end else begin
        m_busy = 0;
        m_credit = 0;
        if (!m_fixed) m_ptr = (m_owner + 1) % WIDTH;
      end
    end
  endtask

  // One clock: check outputs of the previous edge, drive new inputs, advance the model.
  task automatic step(input logic r, input logic [1:0] m, input logic [WIDTH*CNT_W-1:0] w,
                      input logic [WIDTH-1:0] rq, input logic a, input logic l);
    logic [WIDTH-1:0] exp_grant;
    @(negedge clk);
    exp_grant = m_busy ? WIDTH'(1 << m_owner) : '0;
    check_val("grant", 32'(grant), 32'(exp_grant));
    check_val("grant_idx", 32'(grant_idx), 32'(m_idx));
    check_val("grant_vld", 32'(grant_vld), 32'(m_busy));
    check_val("onehot0", 32'($countones(grant) <= 1), 32'd1);
    rst_n = r; mode = m; weight = w; req = rq; ack = a; last = l;
    model_update(r, m, w, rq, a, l);
  endtask

  initial begin
    logic [1:0]             r_mode;
    logic [WIDTH*CNT_W-1:0] r_weight;
    rst_n = 1'b0; mode = 2'd0; weight = '0; req = '0; ack = 1'b0; last = 1'b0;
    @(negedge clk);
    @(negedge clk);
    model_reset();

    // Reset state, then plain round robin with all requesters active.
    step(1'b0, 2'd0, '0, 4'b0000, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) step(1'b1, 2'd0, '0, 4'b1111, 1'b1, 1'b1);

    // Weighted: requester 3 holds for three transactions.
    step(1'b0, 2'd0, '0, 4'b0000, 1'b0, 1'b0);
    for (int i = 0; i < 14; i++) step(1'b1, 2'd1, {4'd3, 4'd1, 4'd1, 4'd1}, 4'b1001, 1'b1, 1'b1);

    // Fixed priority: requester 1 always wins.
    for (int i = 0; i < 10; i++) step(1'b1, 2'd2, '0, 4'b1110, 1'b1, 1'b1);

    // Multi-beat lock survives the owner dropping req.
    step(1'b0, 2'd0, '0, 4'b0000, 1'b0, 1'b0);
    step(1'b1, 2'd0, '0, 4'b0010, 1'b0, 1'b0);
    step(1'b1, 2'd0, '0, 4'b0100, 1'b1, 1'b0);
    step(1'b1, 2'd0, '0, 4'b0100, 1'b1, 1'b0);
    step(1'b1, 2'd0, '0, 4'b0100, 1'b1, 1'b0);
    step(1'b1, 2'd0, '0, 4'b0100, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, 2'd0, '0, 4'b0100, 1'b0, 1'b0);
    step(1'b1, 2'd0, '0, 4'b0000, 1'b1, 1'b1);
    step(1'b1, 2'd0, '0, 4'b0000, 1'b1, 1'b1);

    // Zero weight acts as one; mode change mid-grant does not disturb the burst.
    step(1'b0, 2'd0, '0, 4'b0000, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b1, 2'd1, {4'd1, 4'd1, 4'd1, 4'd0}, 4'b0001, 1'b1, 1'b1);
    step(1'b1, 2'd1, {4'd1, 4'd1, 4'd1, 4'd3}, 4'b0011, 1'b0, 1'b0);
    step(1'b1, 2'd1, {4'd1, 4'd1, 4'd1, 4'd3}, 4'b0011, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b1, 2'd2, '0, 4'b0011, 1'b1, 1'b1);

    // Reset in the middle of a grant, then restart from pointer 0.
    for (int i = 0; i < 3; i++) step(1'b1, 2'd0, '0, 4'b1111, 1'b1, 1'b1);
    step(1'b1, 2'd0, '0, 4'b1111, 1'b0, 1'b0);
    step(1'b0, 2'd0, '0, 4'b1111, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 2'd0, '0, 4'b1010, 1'b0, 1'b0);
    step(1'b1, 2'd0, '0, 4'b1010, 1'b1, 1'b1);
    step(1'b1, 2'd0, '0, 4'b1010, 1'b0, 1'b0);

    // Random traffic.
    r_mode = 2'd0;
    r_weight = '0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) r_mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) begin
        for (int k = 0; k < WIDTH; k++) r_weight[k*CNT_W +: CNT_W] = CNT_W'($urandom_range(0, 4));
      end
      step(($urandom_range(0, 63) != 0), r_mode, r_weight, WIDTH'($urandom),
           1'($urandom), 1'($urandom));
    end
    step(1'b1, 2'd0, '0, 4'b0000, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
